// File: rtl/lsu_align_seq_pkg.sv
// Shared definitions for the load/store alignment sequencer: access length
// encodings, FSM state encoding and the byte-lane mask helper.
package lsu_align_seq_pkg;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;
    localparam logic [1:0] LEN_D = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT0 = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_BEAT1 = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    // One bit per byte touched by an access of the given length.
    function automatic logic [7:0] lenmask(input logic [1:0] length);
        case (length)
            LEN_B:   return 8'h01;
            LEN_H:   return 8'h03;
            LEN_W:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align_seq_if.sv
// Request, data-bus and response signals of the alignment sequencer.
// slave is the sequencer's view, master is the execute stage / bus side.
interface lsu_align_seq_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    logic              i_req_valid;
    logic              o_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic [XLEN-1:0]   i_req_wdata;
    logic [1:0]        i_req_length;
    logic              i_req_signed;
    logic              i_req_write;

    logic              o_bus_valid;
    logic              i_bus_ready;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [XLEN-1:0]   o_bus_wdata;
    logic [NB-1:0]     o_bus_we;
    logic              o_bus_write;
    logic              i_bus_rvalid;
    logic [XLEN-1:0]   i_bus_rdata;

    logic              o_rsp_valid;
    logic [XLEN-1:0]   o_rsp_rdata;
    logic              o_rsp_err;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_wdata, i_req_length, i_req_signed, i_req_write,
        input  i_bus_ready, i_bus_rvalid, i_bus_rdata,
        output o_req_ready, o_bus_valid, o_bus_addr, o_bus_wdata, o_bus_we, o_bus_write,
        output o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_wdata, i_req_length, i_req_signed, i_req_write,
        output i_bus_ready, i_bus_rvalid, i_bus_rdata,
        input  o_req_ready, o_bus_valid, o_bus_addr, o_bus_wdata, o_bus_we, o_bus_write,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

endinterface

// File: rtl/lsu_rd_extract.sv
// Read-data extraction: shifts the {hi,lo} beat pair down by the byte
// offset, keeps the accessed bytes and sign- or zero-extends the result.
module lsu_rd_extract
    import lsu_align_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              hi,
    input  logic [XLEN-1:0]              lo,
    input  logic [$clog2(XLEN/8)-1:0]    off,
    input  logic [1:0]                   length,
    input  logic                         is_signed,
    output logic [XLEN-1:0]              result
);
    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] win;
    logic [XLEN-1:0] dmask;
    logic            msb;
    int              bytes;

    // Window the pair, mask to the access size and extend from its top bit.
    always_comb begin
        bytes = 1 << length;
        win   = XLEN'({hi, lo} >> (8 * int'(off)));
        for (int i = 0; i < NB; i++) begin
            dmask[8*i +: 8] = (i < bytes) ? 8'hFF : 8'h00;
        end
        case (length)
            LEN_B:   msb = win[7];
            LEN_H:   msb = win[15];
            LEN_W:   msb = win[31];
            default: msb = win[XLEN-1];
        endcase
        // A full-width access has dmask all ones, so ~dmask adds nothing.
        result = (win & dmask) | ((is_signed && msb) ? ~dmask : '0);
    end

endmodule

// File: rtl/lsu_align_seq.sv
// Load/store alignment sequencer: one request at a time, split into one or
// two NB-aligned bus beats, read data re-aligned on the way back.
//
//   state  | meaning
//   IDLE   | ready for a request
//   BEAT0  | first (or only) bus beat presented
//   WAIT0  | waiting for first beat completion
//   BEAT1  | second beat of a split access presented
//   WAIT1  | waiting for second beat completion
//   RESP   | one-cycle response pulse
module lsu_align_seq
    import lsu_align_seq_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    lsu_align_seq_if.slave    bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q, lo_q, hi_q;
    logic [1:0]        len_q;
    logic              sgn_q, write_q, err_q, split_q;

    logic              accept, split_in, err_in;
    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] base;
    logic [XLEN-1:0]   dmask, wdata_m, rd_result;
    int                bytes_in, bytes_q;

    assign accept   = (state == ST_IDLE) && bus.i_req_valid;
    assign bytes_in = 1 << bus.i_req_length;
    assign split_in = (int'(bus.i_req_addr[OFF_W-1:0]) + bytes_in) > NB;
    assign err_in   = ((bus.i_req_length == LEN_D) && (XLEN == 32)) || (split_in && !MISALIGN_EN);

    assign off_q   = addr_q[OFF_W-1:0];
    assign base    = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign bytes_q = 1 << len_q;

    // Store data limited to the accessed bytes before lane positioning.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            dmask[8*i +: 8] = (i < bytes_q) ? 8'hFF : 8'h00;
        end
        wdata_m = wdata_q & dmask;
    end

    lsu_rd_extract #(.XLEN(XLEN)) u_rd_extract (
        .hi        (hi_q),
        .lo        (lo_q),
        .off       (off_q),
        .length    (len_q),
        .is_signed (sgn_q),
        .result    (rd_result)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Request capture and read-beat capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            sgn_q   <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            if (accept) begin
                addr_q  <= bus.i_req_addr;
                wdata_q <= bus.i_req_wdata;
                len_q   <= bus.i_req_length;
                sgn_q   <= bus.i_req_signed;
                write_q <= bus.i_req_write;
                err_q   <= err_in;
                split_q <= split_in;
                lo_q    <= '0;
                hi_q    <= '0;
            end
            if (state == ST_WAIT0 && bus.i_bus_rvalid) lo_q <= bus.i_bus_rdata;
            if (state == ST_WAIT1 && bus.i_bus_rvalid) hi_q <= bus.i_bus_rdata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.i_req_valid) state_nxt = err_in ? ST_RESP : ST_BEAT0;
            ST_BEAT0: if (bus.i_bus_ready) state_nxt = ST_WAIT0;
            ST_WAIT0: if (bus.i_bus_rvalid) state_nxt = split_q ? ST_BEAT1 : ST_RESP;
            ST_BEAT1: if (bus.i_bus_ready) state_nxt = ST_WAIT1;
            ST_WAIT1: if (bus.i_bus_rvalid) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state so reset clears them immediately.
    always_comb begin
        bus.o_req_ready = (state == ST_IDLE);
        bus.o_bus_valid = 1'b0;
        bus.o_bus_addr  = '0;
        bus.o_bus_wdata = '0;
        bus.o_bus_we    = '0;
        bus.o_bus_write = 1'b0;
        bus.o_rsp_valid = 1'b0;
        bus.o_rsp_err   = 1'b0;
        bus.o_rsp_rdata = '0;
        case (state)
            ST_BEAT0: begin
                bus.o_bus_valid = 1'b1;
                bus.o_bus_addr  = base;
                bus.o_bus_wdata = wdata_m << (8 * int'(off_q));
                bus.o_bus_we    = write_q ? NB'(lenmask(len_q) << off_q) : '0;
                bus.o_bus_write = write_q;
            end
            ST_BEAT1: begin
                bus.o_bus_valid = 1'b1;
                bus.o_bus_addr  = base + ADDR_W'(NB);
                bus.o_bus_wdata = wdata_q >> (8 * (NB - int'(off_q)));
                bus.o_bus_we    = write_q ? NB'(lenmask(len_q) >> (NB - int'(off_q))) : '0;
                bus.o_bus_write = write_q;
            end
            ST_RESP: begin
                bus.o_rsp_valid = 1'b1;
                bus.o_rsp_err   = err_q;
                bus.o_rsp_rdata = (write_q || err_q) ? '0 : rd_result;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_align_seq.sv
// Directed bench for lsu_align_seq (XLEN=32): one instance with misaligned
// splitting enabled, one with it disabled for the error path.
module tb_lsu_align_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_align_seq_if #(.XLEN(32), .ADDR_W(32)) bus_a ();
    lsu_align_seq_if #(.XLEN(32), .ADDR_W(32)) bus_b ();

    lsu_align_seq #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_a)
    );

    lsu_align_seq #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_b)
    );

    int nchk = 0;
    int nerr = 0;

    logic [31:0] b_addr [2];
    logic [31:0] b_wdata[2];
    logic [3:0]  b_we   [2];
    logic        b_write[2];
    int          nbeats, rsp_cyc, unstable;
    logic        got_rsp, rsp_err_s;
    logic [31:0] rsp_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on dut_a and act as a zero-wait bus, optionally
    // holding off the first beat for 'stall' cycles. Results land in globals.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] len,
                          input logic sgn, input logic wr, input logic [31:0] r0,
                          input logic [31:0] r1, input int stall);
        int   stall_left;
        logic pend_rv;
        logic seen;
        int   bi;
        stall_left = stall;
        pend_rv    = 1'b0;
        seen       = 1'b0;
        nbeats     = 0;
        got_rsp    = 1'b0;
        rsp_cyc    = 0;
        unstable   = 0;
        rsp_data   = '0;
        rsp_err_s  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b_addr[i] = 'x; b_wdata[i] = 'x; b_we[i] = 'x; b_write[i] = 1'bx;
        end
        bus_a.i_req_valid  = 1'b1;
        bus_a.i_req_addr   = a;
        bus_a.i_req_wdata  = wd;
        bus_a.i_req_length = len;
        bus_a.i_req_signed = sgn;
        bus_a.i_req_write  = wr;
        @(negedge clk);
        bus_a.i_req_valid = 1'b0;
        for (int cyc = 1; cyc <= 20 && !got_rsp; cyc++) begin
            if (bus_a.o_rsp_valid) begin
                got_rsp   = 1'b1;
                rsp_cyc   = cyc;
                rsp_data  = bus_a.o_rsp_rdata;
                rsp_err_s = bus_a.o_rsp_err;
            end else begin
                bus_a.i_bus_rvalid = pend_rv;
                bus_a.i_bus_rdata  = (nbeats == 1) ? r0 : r1;
                pend_rv            = 1'b0;
                bus_a.i_bus_ready  = 1'b0;
                if (bus_a.o_bus_valid) begin
                    bi = (nbeats < 2) ? nbeats : 1;
                    if (!seen) begin
                        seen        = 1'b1;
                        b_addr[bi]  = bus_a.o_bus_addr;
                        b_wdata[bi] = bus_a.o_bus_wdata;
                        b_we[bi]    = bus_a.o_bus_we;
                        b_write[bi] = bus_a.o_bus_write;
                    end else if (b_addr[bi] !== bus_a.o_bus_addr || b_wdata[bi] !== bus_a.o_bus_wdata ||
                                 b_we[bi] !== bus_a.o_bus_we || b_write[bi] !== bus_a.o_bus_write) begin
                        unstable++;
                    end
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        bus_a.i_bus_ready = 1'b1;
                        nbeats++;
                        pend_rv = 1'b1;
                        seen    = 1'b0;
                    end
                end
                @(negedge clk);
            end
        end
        bus_a.i_bus_rvalid = 1'b0;
        bus_a.i_bus_ready  = 1'b0;
        chk("rsp_seen", got_rsp, 1'b1);
        @(negedge clk);
        chk("rsp_pulse_end", bus_a.o_rsp_valid, 1'b0);
        chk("ready_after", bus_a.o_req_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.i_req_valid = 0; bus_a.i_req_addr = 0; bus_a.i_req_wdata = 0; bus_a.i_req_length = 0;
        bus_a.i_req_signed = 0; bus_a.i_req_write = 0; bus_a.i_bus_ready = 0; bus_a.i_bus_rvalid = 0;
        bus_a.i_bus_rdata = 0;
        bus_b.i_req_valid = 0; bus_b.i_req_addr = 0; bus_b.i_req_wdata = 0; bus_b.i_req_length = 0;
        bus_b.i_req_signed = 0; bus_b.i_req_write = 0; bus_b.i_bus_ready = 0; bus_b.i_bus_rvalid = 0;
        bus_b.i_bus_rdata = 0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_ready", bus_a.o_req_ready, 1'b1);
        chk("rst_outs", {bus_a.o_bus_valid, bus_a.o_rsp_valid, bus_a.o_rsp_err, bus_a.o_bus_we,
                         bus_a.o_bus_write}, '0);
        chk("rst_data", {bus_a.o_bus_addr, bus_a.o_bus_wdata}, '0);
        chk("rst_rdata", bus_a.o_rsp_rdata, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Signed byte load @0x1003
        do_req(32'h0000_1003, 32'h0, 2'b00, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 0);
        chk("lb_beats", nbeats, 1);
        chk("lb_addr", b_addr[0], 32'h0000_1000);
        chk("lb_we", b_we[0], 4'b0000);
        chk("lb_write", b_write[0], 1'b0);
        chk("lb_rdata", rsp_data, 32'hFFFF_FF80);
        chk("lb_err", rsp_err_s, 1'b0);
        chk("lb_latency", rsp_cyc, 3);

        // Aligned halfword store @0x2002
        do_req(32'h0000_2002, 32'h1234_ABCD, 2'b01, 1'b0, 1'b1, 32'h5A5A_5A5A, 32'h0, 0);
        chk("sh_beats", nbeats, 1);
        chk("sh_addr", b_addr[0], 32'h0000_2000);
        chk("sh_we", b_we[0], 4'b1100);
        chk("sh_wdata", b_wdata[0], 32'hABCD_0000);
        chk("sh_write", b_write[0], 1'b1);
        chk("sh_rdata", rsp_data, 32'h0);
        chk("sh_err", rsp_err_s, 1'b0);

        // Misaligned word store @0x1002
        do_req(32'h0000_1002, 32'hAABB_CCDD, 2'b10, 1'b0, 1'b1, 32'h0, 32'h0, 0);
        chk("sw_beats", nbeats, 2);
        chk("sw_addr0", b_addr[0], 32'h0000_1000);
        chk("sw_we0", b_we[0], 4'b1100);
        chk("sw_wdata0", b_wdata[0], 32'hCCDD_0000);
        chk("sw_addr1", b_addr[1], 32'h0000_1004);
        chk("sw_we1", b_we[1], 4'b0011);
        chk("sw_wdata1", b_wdata[1], 32'h0000_AABB);
        chk("sw_latency", rsp_cyc, 5);

        // Misaligned word load @0x1001 with 3-cycle stall on beat0
        do_req(32'h0000_1001, 32'h0, 2'b10, 1'b0, 1'b0, 32'h4433_2211, 32'h8877_6655, 3);
        chk("lw_beats", nbeats, 2);
        chk("lw_hold", unstable, 0);
        chk("lw_addr0", b_addr[0], 32'h0000_1000);
        chk("lw_addr1", b_addr[1], 32'h0000_1004);
        chk("lw_we0", b_we[0], 4'b0000);
        chk("lw_rdata", rsp_data, 32'h5544_3322);
        chk("lw_latency", rsp_cyc, 8);

        // Unsigned halfword load @0x1002 (no extension despite bit 15 set)
        do_req(32'h0000_1002, 32'h0, 2'b01, 1'b0, 1'b0, 32'h8001_7777, 32'h0, 0);
        chk("lhu_rdata", rsp_data, 32'h0000_8001);

        // Signed halfword load @0x0
        do_req(32'h0000_0000, 32'h0, 2'b01, 1'b1, 1'b0, 32'h1234_F00D, 32'h0, 0);
        chk("lh_rdata", rsp_data, 32'hFFFF_F00D);

        // Split load across the top of the address space
        do_req(32'hFFFF_FFFE, 32'h0, 2'b10, 1'b0, 1'b0, 32'h2211_0000, 32'h0000_4433, 0);
        chk("wrap_addr0", b_addr[0], 32'hFFFF_FFFC);
        chk("wrap_addr1", b_addr[1], 32'h0000_0000);
        chk("wrap_rdata", rsp_data, 32'h4433_2211);

        // Doubleword on XLEN=32 is illegal
        do_req(32'h0000_0000, 32'h0, 2'b11, 1'b0, 1'b0, 32'h1111_1111, 32'h0, 0);
        chk("dw_beats", nbeats, 0);
        chk("dw_err", rsp_err_s, 1'b1);
        chk("dw_latency", rsp_cyc, 1);
        chk("dw_rdata", rsp_data, 32'h0);

        // Misaligned halfword with splitting disabled
        bus_b.i_req_valid  = 1'b1;
        bus_b.i_req_addr   = 32'h0000_0003;
        bus_b.i_req_length = 2'b01;
        bus_b.i_req_write  = 1'b0;
        @(negedge clk);
        bus_b.i_req_valid = 1'b0;
        chk("nomis_rsp", bus_b.o_rsp_valid, 1'b1);
        chk("nomis_err", bus_b.o_rsp_err, 1'b1);
        chk("nomis_busv", bus_b.o_bus_valid, 1'b0);
        @(negedge clk);
        chk("nomis_pulse", {bus_b.o_rsp_valid, bus_b.o_rsp_err, bus_b.o_bus_valid}, 3'b000);
        chk("nomis_ready", bus_b.o_req_ready, 1'b1);

        // Reset while waiting for beat0 completion
        bus_a.i_req_valid  = 1'b1;
        bus_a.i_req_addr   = 32'h0000_0000;
        bus_a.i_req_length = 2'b10;
        bus_a.i_req_signed = 1'b0;
        bus_a.i_req_write  = 1'b1;
        bus_a.i_req_wdata  = 32'hCAFE_F00D;
        @(negedge clk);
        bus_a.i_req_valid = 1'b0;
        chk("mid_busv", bus_a.o_bus_valid, 1'b1);
        bus_a.i_bus_ready = 1'b1;
        @(negedge clk);
        bus_a.i_bus_ready = 1'b0;
        chk("mid_busy", bus_a.o_req_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {bus_a.o_bus_valid, bus_a.o_rsp_valid, bus_a.o_rsp_err, bus_a.o_bus_we,
                             bus_a.o_bus_write}, '0);
        chk("mid_rst_data", {bus_a.o_bus_addr, bus_a.o_bus_wdata}, '0);
        chk("mid_rst_idle", bus_a.o_req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus_a.o_req_ready, 1'b1);
        do_req(32'h0000_0000, 32'h0, 2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 0);
        chk("post_rst_beats", nbeats, 1);
        chk("post_rst_rdata", rsp_data, 32'hDEAD_BEEF);
        chk("post_rst_err", rsp_err_s, 1'b0);
        chk("post_rst_lat", rsp_cyc, 3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
